// File: rtl/l1_trig_wb_intercon.sv
// l1_trig_wb_intercon
//   Wishbone 1-to-4 address-decoding interconnect for the L1 trigger
//   register space. wb_adr_i[14:13] selects one of four 13-bit subspaces:
//   00 thresh, 01 control/generator, 10 agc, 11 bq.
//   One transaction is in flight at a time: IDLE -> BUSY -> RESP -> IDLE.
//   Thresh and control accesses are terminated locally (ack, DEAD_DATA)
//   when clock_enabled_i is low, because their logic sits on ifclk.
//   A watchdog ends any BUSY phase that lasts TIMEOUT cycles with an err.
//
// Ports
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   clock_enabled_i         ifclk running (sampled only in IDLE)
//   wb_*_i / wb_*_o         upstream Wishbone slave side
//   <X>_*_o / <X>_*_i       downstream master ports, X = thresh/control/agc/bq
//   dbg_state_o             current FSM state (0 IDLE, 1 BUSY, 2 RESP)
//
// Handshake: an upstream request is accepted in IDLE on wb_cyc_i & wb_stb_i.
// Exactly one of wb_ack_o/wb_err_o/wb_rty_o is high for one cycle to end it,
// unless wb_cyc_i drops during BUSY, which aborts silently. Downstream, the
// selected port holds cyc/stb until the first cycle with ack, err or rty.
module l1_trig_wb_intercon #(
  parameter int          TIMEOUT   = 1024,
  parameter logic [31:0] DEAD_DATA = 32'hFFFFFFFF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        clock_enabled_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [14:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic        thresh_cyc_o,
  output logic        thresh_stb_o,
  output logic        thresh_we_o,
  output logic [12:0] thresh_adr_o,
  output logic [31:0] thresh_dat_o,
  output logic [3:0]  thresh_sel_o,
  input  logic [31:0] thresh_dat_i,
  input  logic        thresh_ack_i,
  input  logic        thresh_err_i,
  input  logic        thresh_rty_i,
  output logic        control_cyc_o,
  output logic        control_stb_o,
  output logic        control_we_o,
  output logic [12:0] control_adr_o,
  output logic [31:0] control_dat_o,
  output logic [3:0]  control_sel_o,
  input  logic [31:0] control_dat_i,
  input  logic        control_ack_i,
  input  logic        control_err_i,
  input  logic        control_rty_i,
  output logic        agc_cyc_o,
  output logic        agc_stb_o,
  output logic        agc_we_o,
  output logic [12:0] agc_adr_o,
  output logic [31:0] agc_dat_o,
  output logic [3:0]  agc_sel_o,
  input  logic [31:0] agc_dat_i,
  input  logic        agc_ack_i,
  input  logic        agc_err_i,
  input  logic        agc_rty_i,
  output logic        bq_cyc_o,
  output logic        bq_stb_o,
  output logic        bq_we_o,
  output logic [12:0] bq_adr_o,
  output logic [31:0] bq_dat_o,
  output logic [3:0]  bq_sel_o,
  input  logic [31:0] bq_dat_i,
  input  logic        bq_ack_i,
  input  logic        bq_err_i,
  input  logic        bq_rty_i,
  output logic [1:0]  dbg_state_o
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [WW-1:0] r_wdog;
  logic [1:0]  r_tgt;
  logic [3:0]  r_stb;      // one-hot strobe per downstream port
  logic [12:0] r_adr;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;
  logic        r_we;
  logic        r_ack;
  logic        r_err;
  logic        r_rty;
  logic [31:0] r_rdat;

  logic        w_req;
  logic        w_local;
  logic        w_timeout;
  logic        w_rsp_ack;
  logic        w_rsp_err;
  logic        w_rsp_rty;
  logic        w_rsp_any;
  logic [31:0] w_rsp_dat;

  assign w_req     = wb_cyc_i & wb_stb_i;
  // Targets 00 and 01 live on ifclk; without it they can never answer.
  assign w_local   = ~wb_adr_i[14] & ~clock_enabled_i;
  // r_wdog counts completed BUSY cycles; this is the TIMEOUT-th one.
  assign w_timeout = (r_wdog == WW'(TIMEOUT - 1));
  assign w_rsp_any = w_rsp_ack | w_rsp_err | w_rsp_rty;

  // Response select from the latched target
  always_comb begin
    w_rsp_ack = 1'b0;
    w_rsp_err = 1'b0;
    w_rsp_rty = 1'b0;
    w_rsp_dat = 32'd0;
    case (r_tgt)
      2'd0: begin
        w_rsp_ack = thresh_ack_i; w_rsp_err = thresh_err_i;
        w_rsp_rty = thresh_rty_i; w_rsp_dat = thresh_dat_i;
      end
      2'd1: begin
        w_rsp_ack = control_ack_i; w_rsp_err = control_err_i;
        w_rsp_rty = control_rty_i; w_rsp_dat = control_dat_i;
      end
      2'd2: begin
        w_rsp_ack = agc_ack_i; w_rsp_err = agc_err_i;
        w_rsp_rty = agc_rty_i; w_rsp_dat = agc_dat_i;
      end
      default: begin
        w_rsp_ack = bq_ack_i; w_rsp_err = bq_err_i;
        w_rsp_rty = bq_rty_i; w_rsp_dat = bq_dat_i;
      end
    endcase
  end

  // State register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; upstream abort wins over any target response
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_req) w_state_nxt = w_local ? S_RESP : S_BUSY;
      S_BUSY: begin
        if (!wb_cyc_i)                   w_state_nxt = S_IDLE;
        else if (w_rsp_any || w_timeout) w_state_nxt = S_RESP;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_wdog <= '0;
      r_tgt  <= 2'd0;
      r_stb  <= 4'd0;
      r_adr  <= 13'd0;
      r_dat  <= 32'd0;
      r_sel  <= 4'd0;
      r_we   <= 1'b0;
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_rty  <= 1'b0;
      r_rdat <= 32'd0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_rty <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_tgt  <= wb_adr_i[14:13];
            r_adr  <= wb_adr_i[12:0];
            r_dat  <= wb_dat_i;
            r_sel  <= wb_sel_i;
            r_we   <= wb_we_i;
            r_wdog <= '0;
            if (w_local) begin
              r_ack  <= 1'b1;
              r_rdat <= DEAD_DATA;
            end else begin
              r_stb <= 4'b0001 << wb_adr_i[14:13];
            end
          end
        end
        S_BUSY: begin
          if (!wb_cyc_i) begin
            r_stb <= 4'd0;
          end else if (w_rsp_any) begin
            r_stb  <= 4'd0;
            r_rdat <= w_rsp_dat;
            r_err  <= w_rsp_err;
            r_rty  <= ~w_rsp_err & w_rsp_rty;
            r_ack  <= ~w_rsp_err & ~w_rsp_rty & w_rsp_ack;
          end else if (w_timeout) begin
            r_stb <= 4'd0;
            r_err <= 1'b1;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign wb_dat_o = r_rdat;
  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;
  assign wb_rty_o = r_rty;
  assign dbg_state_o = r_state;

  assign thresh_cyc_o  = r_stb[0];
  assign thresh_stb_o  = r_stb[0];
  assign control_cyc_o = r_stb[1];
  assign control_stb_o = r_stb[1];
  assign agc_cyc_o     = r_stb[2];
  assign agc_stb_o     = r_stb[2];
  assign bq_cyc_o      = r_stb[3];
  assign bq_stb_o      = r_stb[3];

  assign thresh_we_o  = r_we;
  assign control_we_o = r_we;
  assign agc_we_o     = r_we;
  assign bq_we_o      = r_we;

  assign thresh_adr_o  = r_adr;
  assign control_adr_o = r_adr;
  assign agc_adr_o     = r_adr;
  assign bq_adr_o      = r_adr;

  assign thresh_dat_o  = r_dat;
  assign control_dat_o = r_dat;
  assign agc_dat_o     = r_dat;
  assign bq_dat_o      = r_dat;

  assign thresh_sel_o  = r_sel;
  assign control_sel_o = r_sel;
  assign agc_sel_o     = r_sel;
  assign bq_sel_o      = r_sel;

endmodule

// File: tb/tb_l1_trig_wb_intercon.sv
// Directed bench for l1_trig_wb_intercon. Inputs change 1 ns after the
// rising edge; outputs are sampled at the same point.
module tb_l1_trig_wb_intercon;

  localparam logic [31:0] DEAD = 32'hFFFFFFFF;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        clk_en;
  logic        u_cyc, u_stb, u_we;
  logic [14:0] u_adr;
  logic [31:0] u_dat;
  logic [3:0]  u_sel;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o, wb_rty_o;
  logic [1:0]  dbg_state;

  logic [3:0]  t_ack, t_err, t_rty;
  logic [31:0] t_dat [4];

  logic [3:0]  cyc_v, stb_v, we_v;
  logic [12:0] adr_v [4];
  logic [31:0] dat_v [4];
  logic [3:0]  sel_v [4];

  int n_cmp = 0;
  int n_bad = 0;

  l1_trig_wb_intercon dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .clock_enabled_i(clk_en),
    .wb_cyc_i(u_cyc), .wb_stb_i(u_stb), .wb_we_i(u_we),
    .wb_adr_i(u_adr), .wb_dat_i(u_dat), .wb_sel_i(u_sel),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
    .thresh_cyc_o(cyc_v[0]), .thresh_stb_o(stb_v[0]), .thresh_we_o(we_v[0]),
    .thresh_adr_o(adr_v[0]), .thresh_dat_o(dat_v[0]), .thresh_sel_o(sel_v[0]),
    .thresh_dat_i(t_dat[0]), .thresh_ack_i(t_ack[0]), .thresh_err_i(t_err[0]), .thresh_rty_i(t_rty[0]),
    .control_cyc_o(cyc_v[1]), .control_stb_o(stb_v[1]), .control_we_o(we_v[1]),
    .control_adr_o(adr_v[1]), .control_dat_o(dat_v[1]), .control_sel_o(sel_v[1]),
    .control_dat_i(t_dat[1]), .control_ack_i(t_ack[1]), .control_err_i(t_err[1]), .control_rty_i(t_rty[1]),
    .agc_cyc_o(cyc_v[2]), .agc_stb_o(stb_v[2]), .agc_we_o(we_v[2]),
    .agc_adr_o(adr_v[2]), .agc_dat_o(dat_v[2]), .agc_sel_o(sel_v[2]),
    .agc_dat_i(t_dat[2]), .agc_ack_i(t_ack[2]), .agc_err_i(t_err[2]), .agc_rty_i(t_rty[2]),
    .bq_cyc_o(cyc_v[3]), .bq_stb_o(stb_v[3]), .bq_we_o(we_v[3]),
    .bq_adr_o(adr_v[3]), .bq_dat_o(dat_v[3]), .bq_sel_o(sel_v[3]),
    .bq_dat_i(t_dat[3]), .bq_ack_i(t_ack[3]), .bq_err_i(t_err[3]), .bq_rty_i(t_rty[3]),
    .dbg_state_o(dbg_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] rsp_bits();
    return {wb_ack_o, wb_err_o, wb_rty_o};
  endfunction

  // driver: request, optional latency, target response kind
  // kind: 0 ack, 1 err, 2 rty, 3 err+ack together
  task automatic xfer(input string tag, input logic [14:0] adr, input logic we,
                      input logic [31:0] wdat, input logic is_local, input int lat,
                      input int kind, input logic [31:0] rdat);
    int tg;
    logic [3:0] oh;
    logic [2:0] exp_rsp;
    tg = int'(adr[14:13]);
    oh = 4'b0001 << tg;
    u_cyc = 1'b1; u_stb = 1'b1; u_we = we; u_adr = adr; u_dat = wdat; u_sel = 4'hF;
    tick();  // edge 0
    if (is_local) begin
      check_eq({tag, " local rsp"}, {29'd0, rsp_bits()}, 32'd4);
      check_eq({tag, " local data"}, wb_dat_o, DEAD);
      check_eq({tag, " local no strobe"}, {28'd0, stb_v | cyc_v}, 32'd0);
      u_cyc = 1'b0; u_stb = 1'b0;
      tick();
      check_eq({tag, " local pulse end"}, {29'd0, rsp_bits()}, 32'd0);
      return;
    end
    check_eq({tag, " strobe"}, {28'd0, stb_v}, {28'd0, oh});
    check_eq({tag, " cyc"}, {28'd0, cyc_v}, {28'd0, oh});
    check_eq({tag, " adr"}, {19'd0, adr_v[tg]}, {19'd0, adr[12:0]});
    if (we) check_eq({tag, " wdat"}, dat_v[tg], wdat);
    for (int i = 0; i < lat; i++) begin
      tick();
      check_eq({tag, " wait strobe"}, {28'd0, stb_v}, {28'd0, oh});
      check_eq({tag, " wait no rsp"}, {29'd0, rsp_bits()}, 32'd0);
    end
    t_dat[tg] = rdat;
    case (kind)
      0: begin t_ack[tg] = 1'b1; exp_rsp = 3'b100; end
      1: begin t_err[tg] = 1'b1; exp_rsp = 3'b010; end
      2: begin t_rty[tg] = 1'b1; exp_rsp = 3'b001; end
      default: begin t_err[tg] = 1'b1; t_ack[tg] = 1'b1; exp_rsp = 3'b010; end
    endcase
    tick();  // edge k: response sampled
    t_ack = 4'd0; t_err = 4'd0; t_rty = 4'd0;
    check_eq({tag, " rsp"}, {29'd0, rsp_bits()}, {29'd0, exp_rsp});
    check_eq({tag, " strobe dropped"}, {28'd0, stb_v}, 32'd0);
    check_eq({tag, " rdat"}, wb_dat_o, rdat);
    tick();  // upstream stb still high here: must not be re-accepted
    u_cyc = 1'b0; u_stb = 1'b0;
    check_eq({tag, " single pulse"}, {29'd0, rsp_bits()}, 32'd0);
    tick();
    check_eq({tag, " no re-accept"}, {28'd0, stb_v}, 32'd0);
    check_eq({tag, " data held"}, wb_dat_o, rdat);
  endtask

  initial begin
    int n;
    clk_en = 1'b1;
    u_cyc = 1'b0; u_stb = 1'b0; u_we = 1'b0; u_adr = '0; u_dat = '0; u_sel = '0;
    t_ack = '0; t_err = '0; t_rty = '0;
    for (int i = 0; i < 4; i++) t_dat[i] = '0;

    #12;
    check_eq("reset rsp", {29'd0, rsp_bits()}, 32'd0);
    check_eq("reset strobes", {24'd0, stb_v, cyc_v}, 32'd0);
    check_eq("reset we", {28'd0, we_v}, 32'd0);
    check_eq("reset dat_o", wb_dat_o, 32'd0);
    check_eq("reset adr", {19'd0, adr_v[2]}, 32'd0);
    check_eq("reset state", {30'd0, dbg_state}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // forwarded write and reads, clock running
    xfer("thr wr", 15'h0004, 1'b1, 32'hA5A50001, 1'b0, 1, 0, 32'h0);
    check_eq("thr we", {31'd0, we_v[0]}, 32'd1);
    xfer("ctl rd", 15'h2010, 1'b0, 32'h0, 1'b0, 0, 0, 32'h11);
    xfer("agc rd", 15'h4020, 1'b0, 32'h0, 1'b0, 3, 0, 32'h22);
    xfer("bq rd",  15'h6030, 1'b0, 32'h0, 1'b0, 0, 0, 32'h33);

    // error / retry / priority from bq
    xfer("bq err", 15'h7FFF, 1'b0, 32'h0, 1'b0, 1, 1, 32'hDEAD0001);
    xfer("bq rty", 15'h6000, 1'b0, 32'h0, 1'b0, 0, 2, 32'h0000BEEF);
    xfer("bq err+ack", 15'h6004, 1'b0, 32'h0, 1'b0, 0, 3, 32'h12345678);

    // ifclk stopped
    clk_en = 1'b0;
    xfer("thr off", 15'h0000, 1'b0, 32'h0, 1'b1, 0, 0, 32'h0);
    xfer("ctl off", 15'h2000, 1'b0, 32'h0, 1'b1, 0, 0, 32'h0);
    xfer("ctl off wr", 15'h3FFF, 1'b1, 32'h55AA55AA, 1'b1, 0, 0, 32'h0);
    xfer("agc off", 15'h4000, 1'b0, 32'h0, 1'b0, 0, 0, 32'h44);
    clk_en = 1'b1;

    // watchdog: agc never answers
    u_cyc = 1'b1; u_stb = 1'b1; u_we = 1'b0; u_adr = 15'h4100;
    tick();
    n = 0;
    while (!wb_err_o && n < 1100) begin
      if (n == 1023) check_eq("wdog stb late", {31'd0, agc_stb_seen()}, 32'd1);
      tick();
      n++;
    end
    check_eq("wdog cycles", n, 32'd1024);
    check_eq("wdog rsp", {29'd0, rsp_bits()}, 32'd2);
    check_eq("wdog stb drop", {28'd0, stb_v}, 32'd0);
    tick();
    u_cyc = 1'b0; u_stb = 1'b0;
    check_eq("wdog pulse end", {29'd0, rsp_bits()}, 32'd0);
    tick();

    // upstream abort during BUSY
    u_cyc = 1'b1; u_stb = 1'b1; u_adr = 15'h6008;
    tick();
    check_eq("abort strobe", {28'd0, stb_v}, 32'h8);
    u_cyc = 1'b0; u_stb = 1'b0;
    tick();
    check_eq("abort clear", {28'd0, stb_v}, 32'd0);
    check_eq("abort no rsp", {29'd0, rsp_bits()}, 32'd0);
    check_eq("abort idle", {30'd0, dbg_state}, 32'd0);
    tick();
    check_eq("abort no late rsp", {29'd0, rsp_bits()}, 32'd0);
    xfer("after abort", 15'h2044, 1'b0, 32'h0, 1'b0, 0, 0, 32'h77);

    // asynchronous reset during BUSY
    u_cyc = 1'b1; u_stb = 1'b1; u_we = 1'b1; u_adr = 15'h4008; u_dat = 32'hCAFEF00D;
    tick();
    check_eq("rst pre strobe", {28'd0, stb_v}, 32'h4);
    #2 rst = 1'b1;
    #1;
    check_eq("rst strobes", {24'd0, stb_v, cyc_v}, 32'd0);
    check_eq("rst we", {28'd0, we_v}, 32'd0);
    check_eq("rst dat", {dat_v[2]}, 32'd0);
    check_eq("rst rsp", {29'd0, rsp_bits()}, 32'd0);
    check_eq("rst rdat", wb_dat_o, 32'd0);
    u_cyc = 1'b0; u_stb = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check_eq("rst after rsp", {29'd0, rsp_bits()}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  function automatic logic agc_stb_seen();
    return stb_v[2];
  endfunction

endmodule
